// File: rtl/coder_framer_pkg.sv
// coder_framer_pkg
// Shared constants and types for the coder output framer.
//   LANES / DEPTH     : lane count and bytes per lane buffer (fixed by the header format)
//   LANE_W / CNT_W    : lane index width and per-lane byte count width (0..DEPTH)
//   HDR_*             : bit positions of the header fields
//   state_e           : framer FSM states
//   make_header       : assembles a header byte from final flag, lane and byte count
package coder_framer_pkg;

    localparam int LANES  = 8;
    localparam int DEPTH  = 16;
    localparam int LANE_W = 3;
    localparam int CNT_W  = 5;

    localparam int HDR_FINAL_BIT = 7;
    localparam int HDR_LANE_MSB  = 6;
    localparam int HDR_LANE_LSB  = 4;
    localparam int HDR_CNT_MSB   = 3;
    localparam int HDR_CNT_LSB   = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The count field carries count-1 so that a full 16-byte lane fits in 4 bits.
    function automatic logic [7:0] make_header(input logic              final_flag,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [CNT_W-1:0]  cnt);
        logic [7:0]       hdr;
        logic [CNT_W-1:0] cnt_m1;
        cnt_m1 = cnt - 1'b1;
        hdr    = '0;
        hdr[HDR_FINAL_BIT]              = final_flag;
        hdr[HDR_LANE_MSB:HDR_LANE_LSB]  = lane;
        hdr[HDR_CNT_MSB:HDR_CNT_LSB]    = cnt_m1[HDR_CNT_MSB:HDR_CNT_LSB];
        return hdr;
    endfunction

endpackage

// File: rtl/coder_framer_if.sv
// coder_framer_if
// Bundles the coder-side input channel and the sink-side output channel of
// the framer.
//   master : drives coder bytes (in_*) and sink readiness (out_ready)
//   slave  : the framer; drives in_ready and the framed output (out_*)
interface coder_framer_if;
    import coder_framer_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bits_idx;
    logic [7:0] in_bits_byte;
    logic       in_bits_last;
    logic       out_valid;
    logic       out_ready;
    logic [HDR_FINAL_BIT:0] out_bits_byte;
    logic       out_bits_last;

    modport master (
        output in_valid, in_bits_idx, in_bits_byte, in_bits_last, out_ready,
        input  in_ready, out_valid, out_bits_byte, out_bits_last
    );

    modport slave (
        input  in_valid, in_bits_idx, in_bits_byte, in_bits_last, out_ready,
        output in_ready, out_valid, out_bits_byte, out_bits_last
    );

endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8
// Eight-way round-robin arbiter.
//   clock, reset : clock and synchronous active-high reset
//   req_i        : one request bit per lane
//   grant_i      : the current winner was taken; pointer advances past it
//   idx_o        : winning lane (first requester at or after the pointer)
//   valid_o      : at least one request is present
module rr_arbiter8 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req_i,
    input  logic       grant_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);
    import coder_framer_pkg::*;

    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic [LANE_W-1:0] cand;

    // Scan offsets from the far end down so the requester closest to the
    // pointer is the one left in idx_o.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + LANE_W'(k);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_i && valid_o) begin
            ptr_d = idx_o + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/coder_out_framer.sv
// coder_out_framer
// Collects coder bytes into eight 16-byte lane buffers and emits each lane as
// a packet: one header byte (final, lane, count-1) followed by its payload.
// Full lanes are emitted round-robin while running; once the last coder byte
// arrives every remaining lane is flushed in ascending order with final set.
//   clock, reset                         : clock, synchronous active-high reset
//   in_valid/in_ready                    : coder byte handshake
//   in_bits_idx/in_bits_byte/in_bits_last: lane (bits [2:0]), data, end of stream
//   out_valid/out_ready                  : framed byte handshake
//   out_bits_byte/out_bits_last          : header or payload, end of framed stream
module coder_out_framer #(
    parameter int LANES = coder_framer_pkg::LANES,
    parameter int DEPTH = coder_framer_pkg::DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_bits_idx,
    input  logic [7:0] in_bits_byte,
    input  logic       in_bits_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_bits_byte,
    output logic       out_bits_last
);
    import coder_framer_pkg::*;

    localparam int               AW      = $clog2(LANES * DEPTH);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q [LANES];
    logic [CNT_W-1:0]   count_d [LANES];
    logic [7:0]         mem_q   [LANES*DEPTH];
    logic               busy_q, busy_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [CNT_W-1:0]   pos_q, pos_d;
    logic               final_q, final_d;
    logic               lastpkt_q, lastpkt_d;
    logic               pending_q, pending_d;

    logic [LANE_W-1:0]  wr_lane;
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic [CNT_W-1:0]   pkt_cnt;
    logic               wr;
    logic               finishing;
    logic               can_start;
    logic [7:0]         req;
    logic               grant;
    logic [LANE_W-1:0]  arb_idx;
    logic               arb_valid;
    logic [LANES-1:0]   nonempty;
    logic               flush_any;
    logic               flush_more;
    logic [LANE_W-1:0]  flush_sel;
    logic               unused_idx;

    assign unused_idx = ^in_bits_idx[7:LANE_W];
    assign wr_lane    = in_bits_idx[LANE_W-1:0];
    assign pkt_cnt    = count_q[lane_q];

    // A lane under emission stays closed to writes until its last payload
    // byte is taken; this keeps header count and payload stable under stall.
    assign in_ready  = !reset && (state_q == RUN) && !pending_q &&
                       (count_q[wr_lane] < FULL) && !(busy_q && (lane_q == wr_lane));
    assign wr        = in_valid && in_ready;
    assign finishing = busy_q && out_ready && (pos_q == pkt_cnt);
    assign can_start = !busy_q || finishing;

    assign wr_addr = AW'(int'(wr_lane) * DEPTH + int'(count_q[wr_lane]));
    assign rd_addr = AW'(int'(lane_q) * DEPTH + int'(pos_q) - 1);

    assign out_valid     = busy_q && !reset;
    assign out_bits_byte = !out_valid    ? 8'h00 :
                           (pos_q == '0) ? make_header(final_q, lane_q, pkt_cnt) :
                                           mem_q[rd_addr];
    assign out_bits_last = out_valid && lastpkt_q && (pos_q == pkt_cnt);

    // Requests look one edge ahead: a write that fills a lane this cycle
    // requests immediately, and the lane finishing this cycle is dropped,
    // so a new packet starts right behind the previous one.
    always_comb begin
        req = '0;
        for (int l = 0; l < LANES; l++) begin
            req[l] = ((count_q[l] == FULL) ||
                      (wr && (wr_lane == LANE_W'(l)) && (count_q[l] == FULL_M1))) &&
                     !(finishing && (lane_q == LANE_W'(l)));
        end
    end

    rr_arbiter8 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   (req),
        .grant_i (grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Flush picks the lowest non-empty lane; flush_more tells whether any
    // other lane remains, i.e. whether this packet carries the stream end.
    always_comb begin
        nonempty   = '0;
        flush_any  = 1'b0;
        flush_more = 1'b0;
        flush_sel  = '0;
        for (int l = 0; l < LANES; l++) begin
            nonempty[l] = (count_q[l] != '0) && !(finishing && (lane_q == LANE_W'(l)));
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            if (nonempty[l]) begin
                flush_more = flush_any;
                flush_sel  = LANE_W'(l);
                flush_any  = 1'b1;
            end
        end
    end

    // Next-state logic: buffer writes, emitter progress and the RUN/FLUSH/DONE
    // sequencing. A last byte defers the flush until the current packet ends.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        lane_d    = lane_q;
        pos_d     = pos_q;
        final_d   = final_q;
        lastpkt_d = lastpkt_q;
        pending_d = pending_q;
        grant     = 1'b0;

        if (wr) begin
            count_d[wr_lane] = count_q[wr_lane] + 1'b1;
        end

        if (busy_q && out_ready) begin
            if (finishing) begin
                busy_d          = 1'b0;
                pos_d           = '0;
                count_d[lane_q] = '0;
                if (lastpkt_q) begin
                    state_d = DONE;
                end
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (pending_q || (wr && in_bits_last)) begin
                    if (can_start) begin
                        state_d   = FLUSH;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end else if (can_start && arb_valid) begin
                    grant     = 1'b1;
                    busy_d    = 1'b1;
                    lane_d    = arb_idx;
                    pos_d     = '0;
                    final_d   = 1'b0;
                    lastpkt_d = 1'b0;
                end
            end
            FLUSH: begin
                if (can_start && flush_any) begin
                    busy_d    = 1'b1;
                    lane_d    = flush_sel;
                    pos_d     = '0;
                    final_d   = 1'b1;
                    lastpkt_d = !flush_more;
                end
            end
            DONE: begin
                for (int l = 0; l < LANES; l++) begin
                    count_d[l] = '0;
                end
                pending_d = 1'b0;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State register; lane storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            busy_q    <= 1'b0;
            lane_q    <= '0;
            pos_q     <= '0;
            final_q   <= 1'b0;
            lastpkt_q <= 1'b0;
            pending_q <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                count_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            lane_q    <= lane_d;
            pos_q     <= pos_d;
            final_q   <= final_d;
            lastpkt_q <= lastpkt_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr) begin
            mem_q[wr_addr] <= in_bits_byte;
        end
    end

endmodule

// File: tb/tb_coder_out_framer.sv
// tb_coder_out_framer
// Drives coder_out_framer through directed scenarios and randomized streams,
// comparing every cycle against a queue-based reference model of the framer.
module tb_coder_out_framer;

    logic clock;
    logic reset;

    coder_framer_if bus();

    coder_out_framer dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (bus.in_valid),
        .in_ready      (bus.in_ready),
        .in_bits_idx   (bus.in_bits_idx),
        .in_bits_byte  (bus.in_bits_byte),
        .in_bits_last  (bus.in_bits_last),
        .out_valid     (bus.out_valid),
        .out_ready     (bus.out_ready),
        .out_bits_byte (bus.out_bits_byte),
        .out_bits_last (bus.out_bits_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: per-lane byte buffers, the packet being emitted as a
    // queue of {last, byte}, round-robin pointer and stream mode.
    logic [7:0] laneMem [8][16];
    int         laneCnt [8];
    logic [8:0] pkt[$];
    logic [8:0] obsQ[$];
    int         curLane;
    int         rrPtr;
    int         mode;       // 0 running, 1 flushing, 2 done
    bit         pending;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int l = 0; l < 8; l++) laneCnt[l] = 0;
        pkt.delete();
        curLane = 0;
        rrPtr   = 0;
        mode    = 0;
        pending = 0;
    endtask

    task automatic startPacket(input int lane, input bit fin, input bit lastPkt);
        int cnt;
        cnt = laneCnt[lane];
        pkt.push_back({1'b0, 8'((fin ? 128 : 0) + lane * 16 + cnt - 1)});
        for (int i = 0; i < cnt; i++) begin
            pkt.push_back({lastPkt && (i == cnt - 1), laneMem[lane][i]});
        end
        curLane = lane;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input bit rstIn, input bit v, input logic [7:0] idx,
                                 input logic [7:0] b, input bit last, input bit ordy,
                                 output bit accepted);
        bit         expReady, expValid, acc, hs, wasActive, finishing, finalDone, canStart, more;
        int         l, found;
        logic [8:0] head;
        reset            = rstIn;
        bus.in_valid     = v;
        bus.in_bits_idx  = idx;
        bus.in_bits_byte = b;
        bus.in_bits_last = last;
        bus.out_ready    = ordy;
        @(negedge clock);
        l = int'(idx[2:0]);
        if (rstIn) begin
            expReady = 0;
            expValid = 0;
        end else begin
            expReady = (mode == 0) && !pending && (laneCnt[l] < 16) && !((pkt.size() != 0) && (curLane == l));
            expValid = (pkt.size() != 0);
        end
        checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
        if (expValid) begin
            checkOutput("out_byte", 32'(bus.out_bits_byte), 32'(pkt[0][7:0]));
            checkOutput("out_last", 32'(bus.out_bits_last), 32'(pkt[0][8]));
        end else if (rstIn) begin
            checkOutput("rst_out_byte", 32'(bus.out_bits_byte), 32'h0);
            checkOutput("rst_out_last", 32'(bus.out_bits_last), 32'h0);
        end
        if (!rstIn && bus.out_valid && ordy) obsQ.push_back({bus.out_bits_last, bus.out_bits_byte});

        accepted = 0;
        if (rstIn) begin
            modelReset();
        end else begin
            acc       = v && expReady;
            accepted  = acc;
            hs        = expValid && ordy;
            wasActive = expValid;
            finishing = 0;
            finalDone = 0;
            if (acc) begin
                laneMem[l][laneCnt[l]] = b;
                laneCnt[l]++;
            end
            if (hs) begin
                head = pkt.pop_front();
                if (pkt.size() == 0) begin
                    finishing        = 1;
                    laneCnt[curLane] = 0;
                    if (head[8]) finalDone = 1;
                end
            end
            canStart = !wasActive || finishing;
            case (mode)
                0: begin
                    if (pending || (acc && last)) begin
                        if (canStart) begin
                            mode    = 1;
                            pending = 0;
                        end else begin
                            pending = 1;
                        end
                    end else if (canStart) begin
                        found = -1;
                        for (int k = 0; k < 8; k++) begin
                            if (found < 0 && laneCnt[(rrPtr + k) % 8] == 16) found = (rrPtr + k) % 8;
                        end
                        if (found >= 0) begin
                            startPacket(found, 0, 0);
                            rrPtr = (found + 1) % 8;
                        end
                    end
                end
                1: begin
                    if (finalDone) begin
                        mode = 2;
                    end else if (canStart) begin
                        found = -1;
                        more  = 0;
                        for (int k = 0; k < 8; k++) begin
                            if (laneCnt[k] > 0) begin
                                if (found < 0) found = k;
                                else more = 1;
                            end
                        end
                        if (found >= 0) startPacket(found, 1, !more);
                    end
                end
                default: begin
                    for (int k = 0; k < 8; k++) laneCnt[k] = 0;
                    mode    = 0;
                    pending = 0;
                end
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycles(input int n, input bit randomReady);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, randomReady ? ($urandom_range(0, 2) != 0) : 1'b1, acc);
        end
    endtask

    task automatic doReset(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 8'h00, 0, 1, acc);
    endtask

    task automatic drainOutputs(input bit randomReady);
        int budget;
        bit acc;
        budget = 600;
        while ((pkt.size() != 0 || mode != 0 || pending) && budget > 0) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, randomReady ? ($urandom_range(0, 2) != 0) : 1'b1, acc);
            budget--;
        end
        if (budget == 0) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic writeLane(input int lane, input int n, input logic [7:0] base, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 8'(lane), base + 8'(i), 0, ordy, acc);
        end
    endtask

    initial begin
        bit         acc;
        int         budget;
        logic [8:0] expSeq[$];

        bus.in_valid = 0; bus.in_bits_idx = 0; bus.in_bits_byte = 0;
        bus.in_bits_last = 0; bus.out_ready = 0; reset = 1;
        modelReset();
        #1;

        // Lane 3 fills with 00..0F: header 3F one cycle later, then payload.
        doReset(2);
        obsQ.delete();
        writeLane(3, 16, 8'h00, 1);
        drainOutputs(0);
        expSeq.delete();
        expSeq.push_back(9'h03F);
        for (int i = 0; i < 16; i++) expSeq.push_back(9'(i));
        checkOutput("lane3_len", 32'(obsQ.size()), 32'(expSeq.size()));
        for (int i = 0; i < expSeq.size() && i < obsQ.size(); i++) checkOutput("lane3_seq", 32'(obsQ[i]), 32'(expSeq[i]));

        // Stalled lane 0 packet; lanes 5 and 1 become full behind it.
        doReset(2);
        obsQ.delete();
        writeLane(0, 16, 8'h40, 0);
        applyStimulus(0, 1, 8'h00, 8'hEE, 0, 0, acc);
        checkOutput("full_lane_refused", 32'(acc), 32'd0);
        writeLane(5, 16, 8'h50, 0);
        writeLane(1, 16, 8'h10, 0);
        drainOutputs(0);
        checkOutput("rr_len", 32'(obsQ.size()), 32'd51);
        if (obsQ.size() == 51) begin
            checkOutput("rr_hdr0", 32'(obsQ[0]), 32'h00F);
            checkOutput("rr_hdr1", 32'(obsQ[17]), 32'h01F);
            checkOutput("rr_hdr5", 32'(obsQ[34]), 32'h05F);
            checkOutput("rr_lane0_end", 32'(obsQ[16]), 32'h04F);
        end

        // Partial lanes flushed by the last byte.
        doReset(2);
        obsQ.delete();
        applyStimulus(0, 1, 8'h02, 8'hAA, 0, 1, acc);
        applyStimulus(0, 1, 8'h02, 8'hBB, 0, 1, acc);
        applyStimulus(0, 1, 8'h02, 8'hCC, 0, 1, acc);
        applyStimulus(0, 1, 8'h07, 8'hDD, 1, 1, acc);
        drainOutputs(0);
        expSeq.delete();
        expSeq = '{9'h0A2, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0F0, 9'h1DD};
        checkOutput("flush_len", 32'(obsQ.size()), 32'd6);
        for (int i = 0; i < 6 && i < obsQ.size(); i++) checkOutput("flush_seq", 32'(obsQ[i]), 32'(expSeq[i]));

        // Reset in the middle of a lane 0 payload, then a fresh two-byte stream.
        doReset(2);
        writeLane(0, 16, 8'h80, 1);
        idleCycles(5, 0);
        doReset(2);
        obsQ.delete();
        applyStimulus(0, 1, 8'h06, 8'h5A, 0, 1, acc);
        applyStimulus(0, 1, 8'h06, 8'hC3, 1, 1, acc);
        drainOutputs(0);
        expSeq = '{9'h0E1, 9'h05A, 9'h1C3};
        checkOutput("rst_len", 32'(obsQ.size()), 32'd3);
        for (int i = 0; i < 3 && i < obsQ.size(); i++) checkOutput("rst_seq", 32'(obsQ[i]), 32'(expSeq[i]));

        // Randomized streams with random sink stalls and noisy upper idx bits.
        for (int s = 0; s < 4; s++) begin
            doReset(2);
            for (int c = 0; c < 300; c++) begin
                logic [7:0] idx;
                idx = 8'($urandom);
                if (s < 2) idx[2] = 1'b0;
                applyStimulus(0, $urandom_range(0, 3) != 0, idx, 8'($urandom), 0,
                              $urandom_range(0, 2) != 0, acc);
            end
            budget = 300;
            acc    = 0;
            while (!acc && budget > 0) begin
                applyStimulus(0, 1, 8'($urandom), 8'($urandom), 1, $urandom_range(0, 2) != 0, acc);
                budget--;
            end
            if (budget == 0) checkOutput("last_accept_timeout", 32'd0, 32'd1);
            drainOutputs(1);
            idleCycles(3, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/coder_out_framer.md
CODER_OUT_FRAMER -- requirements
Module: coder_out_framer

Interface
REQ-001 SHALL have parameter LANES, default 8: number of coder lanes (idx[2:0]); header format fixes it at 8.
REQ-002 SHALL have parameter DEPTH, default 16: bytes per lane buffer; header format fixes it at 16.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: coder byte valid.
REQ-006 SHALL have port in_ready, output, 1: coder byte accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_bits_idx, input, 8: lane index; only bits [2:0] are used.
REQ-008 SHALL have port in_bits_byte, input, 8: coder output byte.
REQ-009 SHALL have port in_bits_last, input, 1: final byte of the coder stream.
REQ-010 SHALL have port out_valid, output, 1: framed byte valid.
REQ-011 SHALL have port out_ready, input, 1: sink ready.
REQ-012 SHALL have port out_bits_byte, output, 8: header or payload byte.
REQ-013 SHALL have port out_bits_last, output, 1: final byte of the framed stream.

Function
REQ-014 SHALL buffer each accepted byte in the lane buffer selected by in_bits_idx[2:0] (128x8 storage, address = lane*16 + count[lane]); each count is 5 bits, 0..16.
REQ-015 SHALL drive in_ready = (state==RUN) && count[in_bits_idx[2:0]] < 16 && lane not currently being emitted; ready may depend on idx.
REQ-016 SHALL have states RUN (accept and emit full lanes), FLUSH (emit residual lanes) and DONE (wait one cycle, then clear and return to RUN).
REQ-017 In RUN, a lane becomes eligible when its count reaches 16; a round-robin arbiter picks one eligible lane; its pointer is 0 after reset and moves to winner+1 mod 8.
REQ-018 Each packet SHALL be one header byte followed by count bytes in write order.
REQ-019 Header format: bit7 = final flag; bits6:4 = lane; bits3:0 = count-1.
REQ-020 When a write fills a lane at edge t and the output is idle, out_valid with that lane's header SHALL be high after edge t (one-cycle latency).
REQ-021 A lane's count SHALL clear on the handshake of its last payload byte; the lane SHALL be non-ready from grant until that handshake.
REQ-022 Writes to other lanes SHALL proceed while a packet is being emitted.
REQ-023 Accepting a byte with in_bits_last=1 SHALL move the FSM to FLUSH after any in-progress packet completes; in_ready SHALL be 0 in FLUSH and DONE.
REQ-024 FLUSH SHALL emit packets with final=1, in ascending lane order, for every lane with count>0 (full lanes included); empty lanes emit nothing.
REQ-025 out_bits_last SHALL be 1 only on the last payload byte of the last non-empty lane in FLUSH.
REQ-026 The handshake of that byte SHALL transition the FSM to DONE.
REQ-027 While out_valid=1 and out_ready=0, out_bits_byte and out_bits_last SHALL hold stable.
REQ-028 out_valid SHALL NOT drop before handshake.
REQ-029 Back-to-back packets SHALL incur no idle cycle when another lane is already eligible.

Reset
REQ-030 reset SHALL force: state=RUN; all counts=0; arbiter pointer=0; out_valid=0; out_bits_last=0; out_bits_byte=0; in_ready=0 during reset.
REQ-031 Reset mid-packet SHALL discard buffered data and any partial packet; the first cycle after reset behaves as a fresh stream.
REQ-032 Buffer storage SHALL need no reset.

Structure
REQ-033 A shared package coder_framer_pkg SHALL hold LANES, DEPTH, the header bit positions and the state enum {RUN, FLUSH, DONE}.
REQ-034 The round-robin selection SHALL be a sub-module rr_arbiter8, with an 8-bit request input, a grant input, and a 3-bit index plus valid output.

Verification
REQ-035 16 bytes 0x00..0x0F on lane 3, out_ready=1 -> header 0x3F, then bytes 0x00..0x0F; header valid one cycle after the 16th accept.
REQ-036 Lanes 1 and 5 both reach 16 on the same edge, pointer=0 -> lane 1 packet (0x1F) is emitted first, then lane 5 (0x5F) with no gap; pointer ends at 6.
REQ-037 Lane 2 gets 3 bytes AA BB CC, lane 7 gets 1 byte DD with last -> 0xA2 AA BB CC, 0xF0 DD; out_bits_last only on DD.
REQ-038 17th byte offered to a full lane 4 with out_ready=0 -> in_ready=0 until lane 4's payload completes; no data lost or duplicated.
REQ-039 Random out_ready stalls during a payload -> byte and last remain stable while stalled; the output sequence is identical to the no-stall run.
REQ-040 reset asserted mid-payload of lane 0, then 2 bytes plus last on lane 6 -> output is exactly 0xE1, b0, b1.
